// File: rtl/food_placer_pkg.sv
// Shared snake-game definitions: coordinate widths, arena bounds, cell grid and the
// food placer FSM encoding. Generator, occupancy map and renderer use the same values.
package food_placer_pkg;

    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    localparam int CELL_SHIFT  = 2;
    localparam int ARENA_X_MIN = 15;
    localparam int ARENA_X_MAX = 145;
    localparam int ARENA_Y_MIN = 10;
    localparam int ARENA_Y_MAX = 110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_LATCH,
        ST_QUERY,
        ST_CHECK
    } place_state_t;

    function automatic logic [X_W-1:0] snap_x(input logic [X_W-1:0] v, input int shift);
        logic [X_W-1:0] mask;
        mask = '1;
        mask = mask << shift;
        return v & mask;
    endfunction

    function automatic logic [Y_W-1:0] snap_y(input logic [Y_W-1:0] v, input int shift);
        logic [Y_W-1:0] mask;
        mask = '1;
        mask = mask << shift;
        return v & mask;
    endfunction

endpackage

// File: rtl/food_placer_if.sv
// Food placer bus: generator step/coords, occupancy query/answer, food result.
// master drives requests and answers (game logic side); slave is the placer.
interface food_placer_if;
    import food_placer_pkg::*;

    logic           place_req;
    logic [X_W-1:0] rand_x;
    logic [Y_W-1:0] rand_y;
    logic           lfsr_enable;
    logic           occ_req;
    logic [X_W-1:0] occ_x;
    logic [Y_W-1:0] occ_y;
    logic           occ_hit;
    logic [X_W-1:0] food_x;
    logic [Y_W-1:0] food_y;
    logic           food_valid;
    logic           place_done;
    logic           place_fail;
    logic           busy;

    modport master (
        output place_req, rand_x, rand_y, occ_hit,
        input  lfsr_enable, occ_req, occ_x, occ_y,
        input  food_x, food_y, food_valid, place_done, place_fail, busy
    );

    modport slave (
        input  place_req, rand_x, rand_y, occ_hit,
        output lfsr_enable, occ_req, occ_x, occ_y,
        output food_x, food_y, food_valid, place_done, place_fail, busy
    );

endinterface

// File: rtl/food_cand_check.sv
// Snaps a raw coordinate to the cell grid and checks arena bounds and inequality with prev.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module food_cand_check
    import food_placer_pkg::*;
#(
    parameter int GRID_SHIFT = CELL_SHIFT,
    parameter int X_MIN      = ARENA_X_MIN,
    parameter int X_MAX      = ARENA_X_MAX,
    parameter int Y_MIN      = ARENA_Y_MIN,
    parameter int Y_MAX      = ARENA_Y_MAX
) (
    input  logic [X_W-1:0] raw_x,
    input  logic [Y_W-1:0] raw_y,
    input  logic [X_W-1:0] prev_x,
    input  logic [Y_W-1:0] prev_y,
    output logic [X_W-1:0] cand_x,
    output logic [Y_W-1:0] cand_y,
    output logic           in_range
);
    localparam logic [X_W-1:0] XLO = X_W'(X_MIN);
    localparam logic [X_W-1:0] XHI = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YLO = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] YHI = Y_W'(Y_MAX);

    // in_range also demands the snapped cell differ from prev, so food always moves
    always_comb begin
        cand_x   = snap_x(raw_x, GRID_SHIFT);
        cand_y   = snap_y(raw_y, GRID_SHIFT);
        in_range = (cand_x >= XLO) && (cand_x <= XHI) &&
                   (cand_y >= YLO) && (cand_y <= YHI) &&
                   !((cand_x == prev_x) && (cand_y == prev_y));
    end

endmodule

// File: rtl/food_placer.sv
// Places food on a free, in-arena grid cell, retrying with fresh random coords; falls back on exhaustion.
// Latency: place_done 5 cycles after place_req on first try, +4 per reject, at most 1+4*MAX_TRIES.
// Backpressure: none; place_req while busy is dropped, never queued.
module food_placer
    import food_placer_pkg::*;
#(
    parameter int GRID_SHIFT = CELL_SHIFT,
    parameter int X_MIN      = ARENA_X_MIN,
    parameter int X_MAX      = ARENA_X_MAX,
    parameter int Y_MIN      = ARENA_Y_MIN,
    parameter int Y_MAX      = ARENA_Y_MAX,
    parameter int MAX_TRIES  = 8,
    parameter int FALLBACK_X = 80,
    parameter int FALLBACK_Y = 60
) (
    input logic          clk,
    input logic          reset,
    food_placer_if.slave bus
);
    localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [X_W-1:0]   FB_X     = X_W'(FALLBACK_X);
    localparam logic [Y_W-1:0]   FB_Y     = Y_W'(FALLBACK_Y);

    place_state_t     state;
    logic [TRY_W-1:0] tries;
    logic [X_W-1:0]   cand_x_c;
    logic [Y_W-1:0]   cand_y_c;
    logic             cand_in_range;
    logic             cand_ok;
    logic             lfsr_enable_q;
    logic             occ_req_q;
    logic [X_W-1:0]   occ_x_q;
    logic [Y_W-1:0]   occ_y_q;
    logic [X_W-1:0]   food_x_q;
    logic [Y_W-1:0]   food_y_q;
    logic             food_valid_q;
    logic             place_done_q;
    logic             place_fail_q;
    logic             busy_q;

    // Food is frozen during a search, so the bounds/duplicate verdict can be taken at LATCH.
    food_cand_check #(
        .GRID_SHIFT (GRID_SHIFT),
        .X_MIN      (X_MIN),
        .X_MAX      (X_MAX),
        .Y_MIN      (Y_MIN),
        .Y_MAX      (Y_MAX)
    ) u_cand_check (
        .raw_x    (bus.rand_x),
        .raw_y    (bus.rand_y),
        .prev_x   (food_x_q),
        .prev_y   (food_y_q),
        .cand_x   (cand_x_c),
        .cand_y   (cand_y_c),
        .in_range (cand_in_range)
    );

    // occ_x_q/occ_y_q double as the candidate registers for the rest of the try.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            tries         <= '0;
            cand_ok       <= 1'b0;
            lfsr_enable_q <= 1'b0;
            occ_req_q     <= 1'b0;
            occ_x_q       <= '0;
            occ_y_q       <= '0;
            food_x_q      <= FB_X;
            food_y_q      <= FB_Y;
            food_valid_q  <= 1'b0;
            place_done_q  <= 1'b0;
            place_fail_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            lfsr_enable_q <= 1'b0;
            occ_req_q     <= 1'b0;
            place_done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.place_req) begin
                        food_valid_q  <= 1'b0;
                        place_fail_q  <= 1'b0;
                        tries         <= '0;
                        lfsr_enable_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state         <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    occ_x_q   <= cand_x_c;
                    occ_y_q   <= cand_y_c;
                    cand_ok   <= cand_in_range;
                    occ_req_q <= 1'b1;
                    state     <= ST_QUERY;
                end
                ST_QUERY: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cand_ok && !bus.occ_hit) begin
                        food_x_q     <= occ_x_q;
                        food_y_q     <= occ_y_q;
                        food_valid_q <= 1'b1;
                        place_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (tries == LAST_TRY) begin
                        food_x_q     <= FB_X;
                        food_y_q     <= FB_Y;
                        food_valid_q <= 1'b1;
                        place_fail_q <= 1'b1;
                        place_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        tries         <= tries + 1'b1;
                        lfsr_enable_q <= 1'b1;
                        state         <= ST_STEP;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.lfsr_enable = lfsr_enable_q;
    assign bus.occ_req     = occ_req_q;
    assign bus.occ_x       = occ_x_q;
    assign bus.occ_y       = occ_y_q;
    assign bus.food_x      = food_x_q;
    assign bus.food_y      = food_y_q;
    assign bus.food_valid  = food_valid_q;
    assign bus.place_done  = place_done_q;
    assign bus.place_fail  = place_fail_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_food_placer.sv
// Randomized bench for food_placer: a generator/occupancy responder replays per-placement
// plans, and a try-list model predicts food, fallback, completion cycle and pulse counts.
module tb_food_placer;
    import food_placer_pkg::*;

    localparam int MAX_TRIES = 8;
    localparam int BUDGET    = 60;

    logic clk = 1'b0;
    logic reset;

    food_placer_if bus ();

    food_placer #(
        .GRID_SHIFT (2),
        .X_MIN      (15),
        .X_MAX      (145),
        .Y_MIN      (10),
        .Y_MAX      (110),
        .MAX_TRIES  (MAX_TRIES),
        .FALLBACK_X (80),
        .FALLBACK_Y (60)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int plan_x [MAX_TRIES];
    int plan_y [MAX_TRIES];
    bit plan_hit [MAX_TRIES];
    int step_idx = 0;
    int q_idx = 0;
    int lfsr_cnt = 0;
    int obs_x [$];
    int obs_y [$];
    int mfx = 80;
    int mfy = 60;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the planned tries in order; first legal cell wins, else fallback.
    task automatic model(output int e_done, output int e_fx, output int e_fy,
                         output int e_fail, output int e_steps);
        int sx, sy;
        e_fail = 1; e_fx = 80; e_fy = 60; e_steps = MAX_TRIES;
        for (int i = 0; i < MAX_TRIES; i++) begin
            sx = (plan_x[i] / 4) * 4;
            sy = (plan_y[i] / 4) * 4;
            if (!plan_hit[i] && sx >= 15 && sx <= 145 && sy >= 10 && sy <= 110 &&
                !(sx == mfx && sy == mfy)) begin
                e_fail = 0; e_fx = sx; e_fy = sy; e_steps = i + 1;
                break;
            end
        end
        e_done = 1 + 4 * e_steps;
    endtask

    // Generator steps on the edge that ends an lfsr_enable cycle; occupancy answers in the
    // cycle after occ_req and is noise at every other time.
    initial begin : env
        bit lf_seen, oq_seen;
        bus.rand_x = '0; bus.rand_y = '0; bus.occ_hit = 1'b0;
        forever begin
            @(negedge clk);
            lf_seen = bus.lfsr_enable;
            oq_seen = bus.occ_req;
            if (lf_seen) lfsr_cnt++;
            if (oq_seen) begin
                obs_x.push_back(int'(bus.occ_x));
                obs_y.push_back(int'(bus.occ_y));
            end
            @(posedge clk);
            #1;
            if (lf_seen && step_idx < MAX_TRIES) begin
                bus.rand_x = 8'(plan_x[step_idx]);
                bus.rand_y = 7'(plan_y[step_idx]);
                step_idx++;
            end
            if (oq_seen && q_idx < MAX_TRIES) begin
                bus.occ_hit = plan_hit[q_idx];
                q_idx++;
            end else begin
                bus.occ_hit = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic set_plan(input int x, input int y, input bit hit);
        for (int i = 0; i < MAX_TRIES; i++) begin
            plan_x[i] = x; plan_y[i] = y; plan_hit[i] = hit;
        end
    endtask

    task automatic do_place(input bit chained, input int p1, input int p2, input bit chain_next);
        int e_done, e_fx, e_fy, e_fail, e_steps;
        int done_cyc, first_lf, first_oq, nq;
        model(e_done, e_fx, e_fy, e_fail, e_steps);
        step_idx = 0; q_idx = 0; lfsr_cnt = 0;
        obs_x.delete(); obs_y.delete();
        if (!chained) begin
            @(posedge clk);
            #1;
            bus.place_req = 1'b1;
        end
        done_cyc = -1; first_lf = -1; first_oq = -1;
        for (int n = 1; n <= BUDGET; n++) begin
            @(posedge clk);
            #1;
            bus.place_req = (n == p1 || n == p2);
            @(negedge clk);
            if (n == 1) begin
                check_val("busy_c1", int'(bus.busy), 1);
                check_val("valid_c1", int'(bus.food_valid), 0);
            end
            if (bus.lfsr_enable && first_lf < 0) first_lf = n;
            if (bus.occ_req && first_oq < 0) first_oq = n;
            if (bus.place_done) begin
                done_cyc = n;
                break;
            end
        end
        bus.place_req = chain_next;
        check_val("done_cycle", done_cyc, e_done);
        check_val("food_x", int'(bus.food_x), e_fx);
        check_val("food_y", int'(bus.food_y), e_fy);
        check_val("food_valid", int'(bus.food_valid), 1);
        check_val("place_fail", int'(bus.place_fail), e_fail);
        check_val("busy_done", int'(bus.busy), 0);
        check_val("lfsr_pulses", lfsr_cnt, e_steps);
        check_val("first_lfsr", first_lf, 1);
        check_val("first_occ", first_oq, 3);
        nq = obs_x.size();
        check_val("occ_queries", nq, e_steps);
        for (int i = 0; i < nq && i < MAX_TRIES; i++) begin
            check_val("occ_x", obs_x[i], (plan_x[i] / 4) * 4);
            check_val("occ_y", obs_y[i], (plan_y[i] / 4) * 4);
        end
        mfx = e_fx; mfy = e_fy;
        if (!chain_next) begin
            @(negedge clk);
            check_val("done_single", int'(bus.place_done), 0);
            check_val("idle_after", int'(bus.busy), 0);
            check_val("food_hold", int'(bus.food_x), e_fx);
        end
    endtask

    task automatic reset_mid_check();
        set_plan(100, 100, 1'b0);
        step_idx = 0; q_idx = 0;
        @(posedge clk);
        #1;
        bus.place_req = 1'b1;
        @(posedge clk);
        #1;
        bus.place_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pre_busy", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check_val("rst_food_x", int'(bus.food_x), 80);
        check_val("rst_food_y", int'(bus.food_y), 60);
        check_val("rst_valid", int'(bus.food_valid), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_strobes", int'({bus.lfsr_enable, bus.occ_req, bus.place_done}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mfx = 80; mfy = 60;
    endtask

    initial begin : main
        int e_done, e_fx, e_fy, e_fail, e_steps;
        bit chain;
        reset = 1'b1;
        bus.place_req = 1'b0;
        #1;
        check_val("init_food_x", int'(bus.food_x), 80);
        check_val("init_food_y", int'(bus.food_y), 60);
        check_val("init_valid", int'(bus.food_valid), 0);
        check_val("init_fail", int'(bus.place_fail), 0);
        check_val("init_busy", int'(bus.busy), 0);
        check_val("init_strobes", int'({bus.lfsr_enable, bus.occ_req, bus.place_done}), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // First-try success
        set_plan(42, 50, 1'b0);
        do_place(1'b0, 0, 0, 1'b0);
        check_val("s2_food", int'({bus.food_x, bus.food_y}), (40 << 7) | 48);

        reset_mid_check();

        // Two occupied hits then success
        set_plan(100, 70, 1'b0);
        plan_hit[0] = 1'b1; plan_hit[1] = 1'b1;
        do_place(1'b0, 0, 0, 1'b0);
        check_val("s3_food", int'({bus.food_x, bus.food_y}), (100 << 7) | 68);

        // Exhaustion -> fallback
        set_plan(100, 70, 1'b1);
        do_place(1'b0, 0, 0, 1'b0);
        check_val("s4_fail", int'(bus.place_fail), 1);

        // Snap below X_MIN, then a good cell; then duplicate of current food, then good
        set_plan(60, 20, 1'b0);
        plan_x[0] = 12; plan_y[0] = 50;
        do_place(1'b0, 0, 0, 1'b0);
        check_val("s5a_food", int'({bus.food_x, bus.food_y}), (60 << 7) | 20);
        set_plan(100, 70, 1'b0);
        plan_x[0] = 61; plan_y[0] = 22;
        do_place(1'b0, 0, 0, 1'b0);
        check_val("s5b_food", int'({bus.food_x, bus.food_y}), (100 << 7) | 68);

        // Ignored place_req mid-search, then a request on the done cycle starts a new search
        set_plan(42, 50, 1'b0);
        plan_hit[0] = 1'b1;
        do_place(1'b0, 2, 4, 1'b1);
        set_plan(20, 20, 1'b0);
        do_place(1'b1, 0, 0, 1'b0);
        check_val("s6_food", int'({bus.food_x, bus.food_y}), (20 << 7) | 20);

        chain = 1'b0;
        for (int t = 0; t < 40; t++) begin
            bit next_chain;
            bit all_hit;
            all_hit = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < MAX_TRIES; i++) begin
                plan_x[i]   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255)
                                                          : $urandom_range(12, 148);
                plan_y[i]   = $urandom_range(0, 127);
                plan_hit[i] = all_hit ? 1'b1 : ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                plan_x[0] = mfx + $urandom_range(0, 3);
                plan_y[0] = mfy + $urandom_range(0, 3);
            end
            model(e_done, e_fx, e_fy, e_fail, e_steps);
            next_chain = ($urandom_range(0, 3) == 0) && (t != 39);
            do_place(chain, $urandom_range(1, 4), $urandom_range(0, 4), next_chain);
            chain = next_chain;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
